// File: rtl/dffram_1r1w_clr.sv
// Parametrised 1R1W DFF RAM with byte write enables, write-first bypass,
// selectable 1/2-cycle read latency and a built-in array clear engine.
module dffram_1r1w_clr #(
  parameter int unsigned WSIZE        = 4,
  parameter int unsigned AW           = 9,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN0,
  input  logic [WSIZE-1:0]     WE0,
  input  logic [AW-1:0]        A0,
  input  logic [8*WSIZE-1:0]   Di0,
  input  logic                 EN1,
  input  logic [AW-1:0]        A1,
  output logic [8*WSIZE-1:0]   Do1,
  output logic                 DO1_VLD,
  input  logic                 CLR_REQ,
  output logic                 READY
);

  localparam int unsigned DW    = 8 * WSIZE;
  localparam int unsigned WORDS = 2 ** AW;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [DW-1:0]   r_mem [WORDS];
  logic [DW-1:0]   r_do1;
  logic            r_vld;

  logic            w_ready;
  logic            w_clr_active;
  logic            w_clr_last;
  logic            w_wr;
  logic            w_rd;
  logic            w_clr_wr;
  logic [DW-1:0]   w_rd_data;

  // The RESET state behaves like its exit state in the first cycle after release.
  assign w_ready      = (r_state == ST_IDLE) ||
                        ((CLR_ON_RESET == 0) && (r_state == ST_RESET) && RST_N);
  assign w_clr_active = (r_state == ST_CLEAR) ||
                        ((CLR_ON_RESET != 0) && (r_state == ST_RESET));
  assign w_clr_last   = (r_cnt == AW'(WORDS - 1));
  assign w_wr         = RST_N && w_ready && EN0;
  assign w_rd         = RST_N && w_ready && EN1;
  assign w_clr_wr     = RST_N && w_clr_active;

  // Control FSM and clear address counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else if (w_clr_active) begin
      if (w_clr_last) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= ST_CLEAR;
        r_cnt   <= r_cnt + AW'(1);
      end
    end else if (w_ready) begin
      if (CLR_REQ) begin
        r_state <= ST_CLEAR;
        r_cnt   <= '0;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Storage array; clearing and user writes never overlap.
  always_ff @(posedge CLK) begin
    if (w_clr_wr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < int'(WSIZE); i++) begin
        if (WE0[i]) begin
          r_mem[A0][8*i +: 8] <= Di0[8*i +: 8];
        end
      end
    end
  end

  // Write-first bypass for lanes written to the address being read.
  always_comb begin
    w_rd_data = r_mem[A1];
    for (int i = 0; i < int'(WSIZE); i++) begin
      if (w_wr && WE0[i] && (A0 == A1)) begin
        w_rd_data[8*i +: 8] = Di0[8*i +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          r_s1_vld;
      logic [DW-1:0] r_s1_data;

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_s1_vld  <= 1'b0;
          r_s1_data <= '0;
          r_vld     <= 1'b0;
          r_do1     <= '0;
        end else begin
          r_s1_vld <= w_rd;
          if (w_rd) begin
            r_s1_data <= w_rd_data;
          end
          r_vld <= r_s1_vld;
          if (r_s1_vld) begin
            r_do1 <= r_s1_data;
          end
        end
      end
    end else begin : g_noreg
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_vld <= 1'b0;
          r_do1 <= '0;
        end else begin
          r_vld <= w_rd;
          if (w_rd) begin
            r_do1 <= w_rd_data;
          end
        end
      end
    end
  endgenerate

  assign Do1     = r_do1;
  assign DO1_VLD = r_vld;
  assign READY   = w_ready;

endmodule
